// File: rtl/boot_mem_writer.sv
// Boot-time program loader: takes a framed word stream (length, data, checksum)
// and writes it into instruction memory while the CPU is held in reset.
module boot_mem_writer #(
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug,
  input  logic              wr_vld,
  input  logic [31:0]       wr_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYC - 1);
  localparam logic [32:0]   MAX_LEN = 33'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [31:0]       sum;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W:0]   wl_next;
  logic              timed_out;
  logic              bad_len;

  assign wl_next   = words_loaded + 1'b1;
  // A strobe in the limit cycle wins over the timeout.
  assign timed_out = !wr_vld && (tcnt == TLIM);
  assign bad_len   = (wr_data == '0) || ({1'b0, wr_data} > MAX_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      sum          <= '0;
      tcnt         <= '0;
    end else begin
      imem_we <= 1'b0;
      // Dropping debug aborts from any state, ahead of any coincident strobe.
      if (!debug) begin
        state     <= IDLE;
        cpu_hold  <= 1'b0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= LEN;
            cpu_hold <= 1'b1;
          end
          LEN: begin
            if (wr_vld) begin
              if (bad_len) begin
                state    <= ERR;
                load_err <= 1'b1;
              end else begin
                len          <= wr_data[ADDR_W:0];
                words_loaded <= '0;
                sum          <= '0;
                tcnt         <= '0;
                state        <= DATA;
              end
            end
          end
          DATA: begin
            if (wr_vld) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= wr_data;
              words_loaded <= wl_next;
              sum          <= sum + wr_data;
              tcnt         <= '0;
              if (wl_next == len) state <= CSUM;
            end else if (timed_out) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          CSUM: begin
            if (wr_vld) begin
              tcnt <= '0;
              if (wr_data == sum) begin
                state     <= DONE;
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end else if (timed_out) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DONE, ERR: ;
          default: begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_mem_writer.sv
// Directed and randomized frames for boot_mem_writer; expectations come from
// frame arithmetic (word sums, counts, idle-cycle budgets) kept in the bench.
module tb_boot_mem_writer;
  localparam int AW = 13;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, debug, wr_vld;
  logic [31:0]   wr_data;
  logic          imem_we, cpu_hold, load_done, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int wl_exp = 0;

  boot_mem_writer #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .debug(debug), .wr_vld(wr_vld), .wr_data(wr_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock with the given strobe, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [31:0] d);
    wr_vld = v; wr_data = d;
    @(posedge clk); #1;
    wr_vld = 1'b0;
  endtask

  task automatic flags(input string tag, input logic hold, input logic done, input logic err);
    chk({tag, "_hold"}, cpu_hold, hold);
    chk({tag, "_done"}, load_done, done);
    chk({tag, "_err"},  load_err, err);
  endtask

  task automatic start();
    debug = 1'b1;
    cyc(1'b0, 32'h0);
    flags("start", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stop();
    debug = 1'b0;
    cyc(1'b0, 32'h0);
    flags("stop", 1'b0, 1'b0, 1'b0);
    chk("stop_wl", words_loaded, wl_exp);
  endtask

  // Full frame from LEN: length, data (with optional idle gaps), checksum.
  task automatic run_frame(input logic [31:0] q[$], input logic [31:0] csum, input int gap);
    logic [31:0] s;
    logic        ok;
    s = 32'h0;
    cyc(1'b1, q.size());
    chk("len_we", imem_we, 1'b0);
    chk("len_wl", words_loaded, 0);
    foreach (q[i]) begin
      repeat (gap) begin
        cyc(1'b0, 32'h0);
        chk("gap_we", imem_we, 1'b0);
      end
      cyc(1'b1, q[i]);
      s = s + q[i];
      chk("wr_we", imem_we, 1'b1);
      chk("wr_addr", imem_addr, i);
      chk("wr_data", imem_wdata, q[i]);
      chk("wr_wl", words_loaded, i + 1);
    end
    cyc(1'b1, csum);
    ok = (csum == s);
    chk("csum_we", imem_we, 1'b0);
    flags("csum", !ok, ok, !ok);
    wl_exp = q.size();
    chk("csum_wl", words_loaded, wl_exp);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] s, w;
    int          n;

    rst = 1'b1; debug = 1'b0; wr_vld = 1'b0; wr_data = 32'h0;
    cyc(1'b0, 32'h0);
    rst = 1'b0;
    flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_wl", words_loaded, 0);

    // Basic 3-word load; strobes in DONE are ignored.
    start();
    q = '{32'h11, 32'h22, 32'h33};
    run_frame(q, 32'h66, 0);
    cyc(1'b1, 32'hDEAD);
    chk("done_ign_we", imem_we, 1'b0);
    chk("done_ign_wl", words_loaded, 3);
    flags("done_ign", 1'b0, 1'b1, 1'b0);
    stop();

    // Checksum wraps modulo 2^32.
    start();
    q = '{32'hFFFF_FFFF, 32'h2};
    run_frame(q, 32'h1, 1);
    stop();
    start();
    run_frame(q, 32'h2, 0);
    stop();

    // Length boundaries.
    start();
    cyc(1'b1, 32'd0);
    flags("len0", 1'b1, 1'b0, 1'b1);
    chk("len0_we", imem_we, 1'b0);
    chk("len0_wl", words_loaded, wl_exp);
    stop();
    start();
    cyc(1'b1, 32'd8193);
    flags("len8193", 1'b1, 1'b0, 1'b1);
    stop();
    start();
    cyc(1'b1, 32'd8192);
    flags("len8192", 1'b1, 1'b0, 1'b0);
    wl_exp = 0;
    chk("len8192_wl", words_loaded, 0);
    cyc(1'b1, 32'hABCD);
    chk("len8192_addr", imem_addr, 0);
    wl_exp = 1;
    stop();

    // LEN never times out.
    start();
    repeat (3 * TO) cyc(1'b0, 32'h0);
    flags("len_noto", 1'b1, 1'b0, 1'b0);
    stop();

    // Timeout after TO idle cycles in DATA.
    start();
    cyc(1'b1, 32'd4);
    cyc(1'b1, 32'h5);
    repeat (TO - 1) cyc(1'b0, 32'h0);
    flags("to_pre", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0);
    flags("to_hit", 1'b1, 1'b0, 1'b1);
    wl_exp = 1;
    stop();

    // Strobe in the last allowed cycle beats the timeout.
    start();
    cyc(1'b1, 32'd4);
    cyc(1'b1, 32'h1);
    repeat (TO - 2) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h2);
    flags("to_save", 1'b1, 1'b0, 1'b0);
    chk("to_save_we", imem_we, 1'b1);
    chk("to_save_addr", imem_addr, 1);
    cyc(1'b1, 32'h3);
    cyc(1'b1, 32'h4);
    repeat (TO - 1) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'hA);
    flags("to_save_done", 1'b0, 1'b1, 1'b0);
    wl_exp = 4;
    stop();

    // Abort coincident with a data strobe, then a fresh load.
    start();
    cyc(1'b1, 32'd3);
    cyc(1'b1, 32'h77);
    debug = 1'b0;
    cyc(1'b1, 32'h88);
    chk("abort_we", imem_we, 1'b0);
    flags("abort", 1'b0, 1'b0, 1'b0);
    chk("abort_wl", words_loaded, 1);
    start();
    q = '{32'h9, 32'hA};
    run_frame(q, 32'h13, 0);
    stop();

    // Reset mid-DATA; strobe while in IDLE is ignored.
    start();
    cyc(1'b1, 32'd5);
    cyc(1'b1, 32'h1234);
    cyc(1'b1, 32'h5678);
    rst = 1'b1;
    cyc(1'b1, 32'h9999);
    rst = 1'b0;
    flags("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_wl", words_loaded, 0);
    cyc(1'b1, 32'd1);
    chk("idle_ign_we", imem_we, 1'b0);
    flags("idle_ign", 1'b1, 1'b0, 1'b0);
    q = '{32'h42};
    run_frame(q, 32'h42, 0);
    stop();

    // Random frames, some with a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 12);
      q = {};
      s = 32'h0;
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        q.push_back(w);
        s = s + w;
      end
      if ($urandom_range(0, 1) == 1) s = s + 32'($urandom_range(1, 1000));
      start();
      run_frame(q, s, $urandom_range(0, 3));
      stop();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_mem_writer.md
BOOT_MEM_WRITER -- requirements
Module: boot_mem_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2_000_000, maximum idle clocks between words in DATA/CSUM.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: one clock, synchronous, active-high.
REQ-005 SHALL have port debug, input, 1, boot-mode enable; low aborts load and releases CPU.
REQ-006 SHALL have port wr_vld, input, 1, one-cycle strobe: upstream assembled word valid.
REQ-007 SHALL have port wr_data, input, 32, assembled word, sampled only when wr_vld=1.
REQ-008 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, ADDR_W, instruction-memory write address.
REQ-010 SHALL have port imem_wdata, output, 32, instruction-memory write data.
REQ-011 SHALL have port cpu_hold, output, 1, holds CPU in reset while a load is pending.
REQ-012 SHALL have port load_done, output, 1, program loaded and checksum matched.
REQ-013 SHALL have port load_err, output, 1, bad length, checksum mismatch or timeout.
REQ-014 SHALL have port words_loaded, output, ADDR_W+1, count of data words written.

Function
REQ-015 SHALL implement FSM states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 SHALL accept frame format: length word N; then N data words; then checksum word = sum of data words mod 2^32.
REQ-017 SHALL move IDLE->LEN in the cycle after debug=1 is sampled.
REQ-018 LEN: on wr_vld, SHALL go to ERR if N==0 or N>2^ADDR_W; otherwise SHALL latch N, clear words_loaded and sum, and go to DATA.
REQ-019 DATA: on wr_vld, SHALL drive imem_we=1, imem_addr=words_loaded[ADDR_W-1:0] and imem_wdata=wr_data, all registered, one cycle after the strobe, for exactly one cycle.
REQ-020 DATA: on wr_vld, SHALL increment words_loaded and add wr_data to the 32-bit sum, wrapping with carry discarded.
REQ-021 DATA: SHALL go to CSUM on the strobe that makes words_loaded==N.
REQ-022 CSUM: on wr_vld, SHALL go to DONE if wr_data==sum, else to ERR; no memory write.
REQ-023 DONE and ERR: SHALL stay until debug=0, then go to IDLE.
REQ-024 SHALL ignore wr_vld in IDLE, DONE and ERR (no write, no count change).
REQ-025 SHALL go to IDLE on the next edge from any state when debug=0; abort has priority over a coincident wr_vld, and no write SHALL issue.
REQ-026 Timeout counter: SHALL clear on wr_vld and on entry to DATA/CSUM; SHALL increment in DATA/CSUM.
REQ-027 SHALL go to ERR on reaching TIMEOUT_CYC-1 without wr_vld; wr_vld in that same cycle SHALL win.
REQ-028 LEN SHALL have no timeout.
REQ-029 cpu_hold SHALL be 1 in LEN, DATA, CSUM, ERR and 0 in IDLE, DONE.
REQ-030 load_done SHALL be 1 only in DONE; load_err SHALL be 1 only in ERR; both registered.
REQ-031 words_loaded SHALL hold its value in DONE/ERR and clear only on LEN acceptance or reset.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=0; load_done=0; load_err=0; words_loaded=0; sum=0; timeout counter=0.
REQ-033 rst mid-load SHALL abort without further writes; memory contents already written are untouched.

Verification
REQ-034 debug=1; words 3, 0x11, 0x22, 0x33, 0x66 -> writes addr0=0x11, addr1=0x22, addr2=0x33, each 1 cycle after its strobe; load_done=1; cpu_hold=0; words_loaded=3.
REQ-035 Length 2; words 0xFFFFFFFF, 0x2; checksum 0x1 -> DONE (wrap); checksum 0x2 -> ERR, load_err=1, cpu_hold=1.
REQ-036 Length 0 -> ERR with no writes; length 8193 -> ERR; debug low -> IDLE, all flags 0.
REQ-037 TIMEOUT_CYC=16; length 4, one word, then 16 idle cycles -> ERR; repeat with a strobe on cycle 15 -> no ERR.
REQ-038 debug drops coincident with a DATA strobe -> no imem_we, IDLE next cycle; debug re-raised -> fresh load with words_loaded=0.
REQ-039 rst pulsed mid-DATA -> all outputs at REQ-032 values next cycle; wr_vld in IDLE ignored.
